// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared defaults and address helpers for the memory responders
package mem_pkg;

  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_DEPTH_W = 10;
  localparam int DEF_LATENCY = 4;

  // Byte address to word index: drop addr[0], keep depth_w bits so addresses alias.
  function automatic logic [31:0] word_index(input logic [31:0] addr, input int depth_w);
    return (addr >> 1) & ((32'd1 << depth_w) - 32'd1);
  endfunction

endpackage

// File: rtl/mem_delay_line.sv
// rtl/mem_delay_line.sv - {valid, data} shift register; wire-through when STAGES is 0
module mem_delay_line #(
  parameter int DATA_W = 16,
  parameter int STAGES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  generate
    if (STAGES == 0) begin : g_wire
      assign out_valid = in_valid;
      assign out_data  = in_data;
    end else begin : g_shift
      logic [STAGES-1:0] valid_q;
      logic [DATA_W-1:0] data_q [STAGES];

      // Only the valid bits are flushed; stale data is harmless once invalid.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q <= '0;
        end else begin
          valid_q[0] <= in_valid;
          for (int i = 1; i < STAGES; i++) begin
            valid_q[i] <= valid_q[i-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        data_q[0] <= in_data;
        for (int i = 1; i < STAGES; i++) begin
          data_q[i] <= data_q[i-1];
        end
      end

      assign out_valid = valid_q[STAGES-1];
      assign out_data  = data_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/dmem_pipe_responder.sv
// rtl/dmem_pipe_responder.sv - pipelined data-memory responder with fixed read latency
module dmem_pipe_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH_W = DEF_DEPTH_W,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         wr,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [DATA_W-1:0]            data_in,
  output logic [DATA_W-1:0]            data_out,
  output logic                         data_valid,
  output logic [$clog2(LATENCY+1)-1:0] rd_pending
);

  localparam int PEND_W = $clog2(LATENCY + 1);

  logic [DATA_W-1:0]  mem [2**DEPTH_W];
  logic [DEPTH_W-1:0] idx;
  logic               rd_accept;
  logic               wr_accept;
  logic               rd_valid_q;
  logic [DATA_W-1:0]  rd_data_q;
  logic               line_valid;
  logic [DATA_W-1:0]  line_data;

  assign idx       = DEPTH_W'(word_index(32'(addr), DEPTH_W));
  assign rd_accept = enable && !wr;
  assign wr_accept = enable && wr;

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[idx] <= data_in;
    end
  end

  // The sample register supplies the first cycle of latency; the delay line the rest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_accept;
      if (rd_accept) begin
        rd_data_q <= mem[idx];
      end
    end
  end

  mem_delay_line #(
    .DATA_W (DATA_W),
    .STAGES (LATENCY - 1)
  ) u_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_valid_q),
    .in_data   (rd_data_q),
    .out_valid (line_valid),
    .out_data  (line_data)
  );

  assign data_valid = line_valid;
  assign data_out   = line_valid ? line_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pending <= '0;
    end else begin
      case ({rd_accept, line_valid})
        2'b10:   rd_pending <= rd_pending + PEND_W'(1);
        2'b01:   rd_pending <= rd_pending - PEND_W'(1);
        default: rd_pending <= rd_pending;
      endcase
    end
  end

endmodule
